// File: rtl/npu_pkg.sv
// Shared NPU constants and the int8 saturation helper used by the output path.
package npu_pkg;

    localparam int ACT_W  = 8;
    localparam int ACC_W  = 16;
    localparam int N_COLS = 3;
    localparam int PACK_W = N_COLS * ACT_W;

    // Clamp a wide signed value into the signed 8-bit activation range.
    function automatic logic [ACT_W-1:0] sat_int8(input logic signed [31:0] x);
        if (x > 32'sd127) begin
            return 8'h7F;
        end else if (x < -32'sd128) begin
            return 8'h80;
        end else begin
            return x[ACT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// The head word is visible on dout whenever valid is high. A push while full
// is accepted only if a pop happens in the same cycle.
module npu_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (level != '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; valid/level gate every read, so contents are don't-care after reset.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/npu_out_collector.sv
// Systolic array output collector: deskews the three bottom-row columns,
// adds bias, optionally applies ReLU, requantizes to int8 with rounding and
// saturation, and queues packed rows in a FWFT FIFO.
module npu_out_collector #(
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_W      = npu_pkg::ACC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [ACC_W-1:0]     col0,
    input  logic signed [ACC_W-1:0]     col1,
    input  logic signed [ACC_W-1:0]     col2,
    input  logic signed [ACC_W-1:0]     bias0,
    input  logic signed [ACC_W-1:0]     bias1,
    input  logic signed [ACC_W-1:0]     bias2,
    input  logic [3:0]                  cfg_shift,
    input  logic                        cfg_relu,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [npu_pkg::PACK_W-1:0]  out_data,
    output logic [4:0]                  fifo_level,
    output logic [7:0]                  row_cnt,
    output logic                        overflow
);

    import npu_pkg::*;

    // Bias add, optional ReLU, round-half-up shift, saturate to int8.
    function automatic logic [ACT_W-1:0] quantize(
        input logic signed [ACC_W-1:0] col,
        input logic signed [ACC_W-1:0] bias,
        input logic [3:0]              shift,
        input logic                    relu
    );
        logic signed [ACC_W:0]   sum;
        logic signed [ACC_W+1:0] rnd;
        logic        [ACC_W+1:0] half;
        // NOTE: every local gets a value on every path before use, so combinational use never infers a latch.
        sum  = (ACC_W+1)'(col) + (ACC_W+1)'(bias);
        half = '0;
        if (relu && sum < 0) sum = '0;
        if (shift != 4'd0) half = (ACC_W+2)'(1) << (shift - 4'd1);
        rnd = (ACC_W+2)'(sum) + signed'(half);
        return sat_int8(32'(rnd >>> shift));
    endfunction

    logic                    flush;
    logic                    v_d1;
    logic                    v_d2;
    logic                    q_valid;
    logic signed [ACC_W-1:0] c0_d1;
    logic signed [ACC_W-1:0] c0_d2;
    logic signed [ACC_W-1:0] c1_d1;
    logic [PACK_W-1:0]       q_data;
    logic                    fifo_full;
    logic                    pop_fire;
    logic                    accept;
    logic                    drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_lvl;

    assign flush    = rst || clear;
    assign pop_fire = out_valid && out_ready;
    assign accept   = q_valid && (!fifo_full || pop_fire);
    assign drop     = q_valid && fifo_full && !pop_fire;

    // Row-valid pipeline: in_valid -> deskew (2) -> quantize (1); flushed rows never reach the FIFO.
    always_ff @(posedge clk) begin
        if (flush) begin
            v_d1    <= 1'b0;
            v_d2    <= 1'b0;
            q_valid <= 1'b0;
        end else begin
            v_d1    <= in_valid;
            v_d2    <= v_d1;
            q_valid <= v_d2;
        end
    end

    // Data path: align col0/col1 with col2, then register the quantized packed row.
    always_ff @(posedge clk) begin
        c0_d1  <= col0;
        c0_d2  <= c0_d1;
        c1_d1  <= col1;
        q_data <= {quantize(col2,  bias2, cfg_shift, cfg_relu),
                   quantize(c1_d1, bias1, cfg_shift, cfg_relu),
                   quantize(c0_d2, bias0, cfg_shift, cfg_relu)};
    end

    npu_sync_fifo #(
        .WIDTH (PACK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (flush),
        .push  (accept),
        .pop   (out_ready),
        .din   (q_data),
        .dout  (out_data),
        .valid (out_valid),
        .full  (fifo_full),
        .level (fifo_lvl)
    );

    assign fifo_level = 5'(fifo_lvl);

    // Accepted-row counter and sticky drop flag.
    always_ff @(posedge clk) begin
        if (flush) begin
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) row_cnt  <= row_cnt + 8'd1;
            if (drop)   overflow <= 1'b1;
        end
    end

endmodule
